play_receiver_rx: RTL and testbench
===================================

Name: play_receiver_rx

Overview:
- Downstream consumer of the play analyser's serial output.
- Deserialises 7E1 UART frames (start, 7 data bits LSB first, even parity, 1 stop) and assembles the 4-character play message: button char, '$', position char, '#'.
- Validates framing, parity and message format, then presents the 28-bit word in the same packing the transmitter uses, {botao, '$', pos, '#'}, with a one-cycle strobe.
- Used on the receiving board, and by the bench as a loopback checker.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit, 50 MHz / 115200. Must be ≥ 4.
- TIMEOUT_BITS, 40: idle bit-times allowed between characters of one message before the partial message is dropped.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial  in  1  UART line, idle high.
- zera  in  1  synchronous clear: same effect as reset, except resposta is held.
- resposta  out  28  last valid message, {c0, c1, c2, c3}, 7 bits each.
- recebido  out  1  one-cycle pulse: resposta has just been updated.
- erro_paridade  out  1  one-cycle pulse: parity or stop-bit error.
- erro_formato  out  1  one-cycle pulse: character illegal for its position.
- ocupado  out  1  high while a frame is in progress, or while the char counter ≠ 0.
- db_estado  out  3  rx FSM state code, for display.

Behaviour:
- **Reset** (reset=0, async): all outputs 0, FSM IDLE, char counter 0, bit/tick counters 0, synchroniser flops 1.
- **Input sync**: serial passes through a 2-flop synchroniser. All sampling uses the synchronised signal, so latency is 2 cycles.
- **Rx FSM states** (db_estado codes):
  - IDLE(0): wait for synced line = 0.
  - START(1): count CLKS_PER_BIT/2 ticks, then resample. 0 → DATA; 1 → IDLE (glitch, no error).
  - DATA(2): sample every CLKS_PER_BIT ticks at mid-bit, 7 samples, shifted in LSB first.
  - PARITY(3): one sample at mid-bit.
  - STOP(4): one sample at mid-bit, then CHECK.
  - CHECK(5): one cycle, then IDLE. A new start bit may be detected from the cycle after CHECK.
- **CHECK, parity/framing**: parity error = XOR of the 7 data bits and the parity bit ≠ 0. Framing error = stop sample is 0. Either → erro_paridade pulse, char counter ← 0, message discarded.
- **CHECK, format by position** (counter = k):
  - k=0: char ∈ {J,Z,Y,R,L,A,B,C,D}.
  - k=1: char = '$' (0x24).
  - k=2: char ∈ '0'..'3' (0x30–0x33).
  - k=3: char = '#' (0x23).
  - On failure: erro_formato pulse, counter ← 0. Resync exception: a failing char that equals '#' restarts at 0 with no error pulse after the error pulse of its own frame — i.e. a '#' seen at k≠3 still pulses erro_formato, and counter ← 0.
- **CHECK, success**: the char is stored in slot k and the counter increments. At k=3 with success: resposta ← {slot0, slot1, slot2, '#'} on the same edge the counter wraps to 0, and recebido = 1 in the following cycle only.
- **Error priority**: parity/framing error takes precedence over format error; only one error pulse per frame.
- **Timeout**: in IDLE with counter ≠ 0, a timer counts cycles. At TIMEOUT_BITS·CLKS_PER_BIT cycles, counter ← 0, silently. The timer resets on every start bit.
- **Hold**: resposta changes only on a successful message and is never partially updated. zera does not clear it; only reset does.
- **zera**: returns the FSM to IDLE and the counter to 0 on the next edge. Any frame in progress is dropped with no pulses.
- **Reset mid-frame**: immediate return to the reset state. The remaining bits of that frame are ignored until the line is seen at 1 and then falls again.

Test Plan:
1. CLKS_PER_BIT=8. Send 'A','$','2','#' back-to-back → resposta = 28'h8291923, exactly one recebido pulse 1 cycle after the '#' CHECK, no error pulses.
2. Send 'J','$','0','#', then 'D','$','3','#' → two recebido pulses, final resposta = {0x44, 0x24, 0x33, 0x23}.
3. Corrupt the parity bit of '$' in 'B$1#' → one erro_paridade pulse, no recebido, resposta unchanged. The following valid 'C$1#' is accepted.
4. Send 'A','$','7','#' → erro_formato at '7' and again at the stray '#' (position 0). A subsequent 'Z$0#' is accepted.
5. Send 'A','$', then idle 41 bit-times, then '2','#' → no recebido; erro_formato on '2' at position 0.
6. A 1-tick low glitch on serial in IDLE → returns to IDLE, no pulses. Pulse reset low mid-DATA → all outputs 0 asynchronously; the next full message is received correctly.

Source files
------------

// File: rtl/play_receiver_rx.sv
// play_receiver_rx: 7E1 UART receiver and play-message assembler.
// Deserialises frames made of a start bit, 7 data bits (LSB first), an even
// parity bit and a stop bit. It assembles the message {button, '$', pos, '#'}
// and publishes it on resposta with a one-cycle recebido strobe.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   serial         UART line, idle high
//   zera           synchronous clear (resposta is kept)
//   resposta       last valid message {c0, c1, c2, c3}, 7 bits per char
//   recebido       one-cycle pulse: resposta just updated
//   erro_paridade  one-cycle pulse: parity or stop-bit error
//   erro_formato   one-cycle pulse: character illegal for its position
//   ocupado        frame in progress or partial message held
//   db_estado      rx FSM state code
module play_receiver_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial,
  input  logic        zera,
  output logic [27:0] resposta,
  output logic        recebido,
  output logic        erro_paridade,
  output logic        erro_formato,
  output logic        ocupado,
  output logic [2:0]  db_estado
);

  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned TICK_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  localparam logic [CHAR_W-1:0] CH_DOLLAR = 7'h24;
  localparam logic [CHAR_W-1:0] CH_HASH   = 7'h23;
  localparam logic [CHAR_W-1:0] CH_ZERO   = 7'h30;
  localparam logic [CHAR_W-1:0] CH_THREE  = 7'h33;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_CHECK  = 3'd5
  } state_t;

  state_t              state;
  logic                sync1, sync2;
  logic                valid1, valid2;
  logic                armed;
  logic [TICK_W-1:0]   tick;
  logic [2:0]          bit_idx;
  logic [CHAR_W-1:0]   shreg;
  logic                par_bit;
  logic                stop_bit;
  logic [1:0]          char_cnt;
  logic [CHAR_W-1:0]   slot0, slot1, slot2;
  logic [TO_W-1:0]     timer;

  logic half_last, bit_last, par_err, frm_err, fmt_ok;

  assign db_estado = state;

  // Bit-timing terminal counts and per-character validity checks
  always_comb begin
    half_last = (tick == TICK_W'(HALF_BIT - 1));
    bit_last  = (tick == TICK_W'(CLKS_PER_BIT - 1));
    par_err   = ^{shreg, par_bit};
    frm_err   = ~stop_bit;
    fmt_ok    = 1'b0;
    case (char_cnt)
      2'd0: fmt_ok = shreg inside {7'h4A, 7'h5A, 7'h59, 7'h52, 7'h4C,
                                   7'h41, 7'h42, 7'h43, 7'h44};
      2'd1: fmt_ok = (shreg == CH_DOLLAR);
      2'd2: fmt_ok = (shreg >= CH_ZERO) && (shreg <= CH_THREE);
      2'd3: fmt_ok = (shreg == CH_HASH);
      default: fmt_ok = 1'b0;
    endcase
  end

  // Synchroniser, rx FSM, message assembly and registered outputs.
  // armed needs the line seen high (after the synchroniser has settled)
  // before a falling level counts as a start bit, so the tail of a frame
  // cut by reset/zera is not mistaken for a new frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      valid1        <= 1'b0;
      valid2        <= 1'b0;
      armed         <= 1'b0;
      state         <= ST_IDLE;
      tick          <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      stop_bit      <= 1'b0;
      char_cnt      <= '0;
      slot0         <= '0;
      slot1         <= '0;
      slot2         <= '0;
      timer         <= '0;
      resposta      <= '0;
      recebido      <= 1'b0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      sync1         <= serial;
      sync2         <= sync1;
      valid1        <= 1'b1;
      valid2        <= valid1;
      recebido      <= 1'b0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      if (valid2 && sync2) armed <= 1'b1;

      if (zera) begin
        state    <= ST_IDLE;
        tick     <= '0;
        bit_idx  <= '0;
        char_cnt <= '0;
        timer    <= '0;
        armed    <= 1'b0;
        ocupado  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tick    <= '0;
            bit_idx <= '0;
            if (armed && !sync2) begin
              state   <= ST_START;
              timer   <= '0;
              armed   <= 1'b0;
              ocupado <= 1'b1;
            end else if (char_cnt != 2'd0) begin
              // Inter-character timeout drops a partial message silently
              if (timer == TO_W'(TO_CYCLES - 1)) begin
                char_cnt <= '0;
                timer    <= '0;
                ocupado  <= 1'b0;
              end else begin
                timer   <= timer + TO_W'(1);
                ocupado <= 1'b1;
              end
            end else begin
              timer   <= '0;
              ocupado <= 1'b0;
            end
          end

          ST_START: begin
            if (half_last) begin
              tick <= '0;
              if (!sync2) begin
                state <= ST_DATA;
              end else begin
                state   <= ST_IDLE;
                ocupado <= (char_cnt != 2'd0);
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          ST_DATA: begin
            if (bit_last) begin
              tick  <= '0;
              shreg <= {sync2, shreg[CHAR_W-1:1]};
              if (bit_idx == 3'd6) begin
                bit_idx <= '0;
                state   <= ST_PARITY;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          ST_PARITY: begin
            if (bit_last) begin
              tick    <= '0;
              par_bit <= sync2;
              state   <= ST_STOP;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          ST_STOP: begin
            if (bit_last) begin
              tick     <= '0;
              stop_bit <= sync2;
              state    <= ST_CHECK;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          ST_CHECK: begin
            state <= ST_IDLE;
            // Line errors outrank format errors; one pulse per frame
            if (par_err || frm_err) begin
              erro_paridade <= 1'b1;
              char_cnt      <= '0;
              ocupado       <= 1'b0;
            end else if (!fmt_ok) begin
              erro_formato <= 1'b1;
              char_cnt     <= '0;
              ocupado      <= 1'b0;
            end else begin
              case (char_cnt)
                2'd0: slot0 <= shreg;
                2'd1: slot1 <= shreg;
                2'd2: slot2 <= shreg;
                default: begin
                  resposta <= {slot0, slot1, slot2, CH_HASH};
                  recebido <= 1'b1;
                end
              endcase
              char_cnt <= char_cnt + 2'd1;
              ocupado  <= (char_cnt != 2'd3);
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_receiver_rx.sv
// Testbench for play_receiver_rx: directed UART frames checked against a
// message-level model (per-frame outcome schedule) plus literal expectations.
module tb_play_receiver_rx;

  localparam int C       = 8;
  localparam int TO_BITS = 40;
  localparam int FRAME   = 10 * C;
  // start edge -> strobe: 2 sync + 1 detect + half bit + 9 bits + check
  localparam int LAT     = 4 + C / 2 + 9 * C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        serial = 1'b1;
  logic        zera = 1'b0;
  logic [27:0] resposta;
  logic        recebido;
  logic        erro_paridade;
  logic        erro_formato;
  logic        ocupado;
  logic [2:0]  db_estado;

  play_receiver_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TO_BITS)) dut (
    .clock         (clock),
    .reset         (reset),
    .serial        (serial),
    .zera          (zera),
    .resposta      (resposta),
    .recebido      (recebido),
    .erro_paridade (erro_paridade),
    .erro_formato  (erro_formato),
    .ocupado       (ocupado),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- message-level model ----------------
  typedef struct {
    int          at;
    bit          rec;
    bit          ep;
    bit          ef;
    logic [27:0] resp;
  } ev_t;

  ev_t         evq[$];
  int          mpos = 0;
  logic [6:0]  mslot [0:2];
  int          last_start = -1;
  logic [27:0] exp_resp = '0;

  function automatic bit legal(input int pos, input logic [6:0] ch);
    case (pos)
      0: return ch inside {7'h4A, 7'h5A, 7'h59, 7'h52, 7'h4C, 7'h41, 7'h42, 7'h43, 7'h44};
      1: return ch == 7'h24;
      2: return (ch >= 7'h30) && (ch <= 7'h33);
      default: return ch == 7'h23;
    endcase
  endfunction

  task automatic model_frame(input logic [6:0] ch, input bit bad_par, input int s);
    ev_t e;
    e.at = s + LAT; e.rec = 0; e.ep = 0; e.ef = 0; e.resp = '0;
    if (mpos != 0 && last_start >= 0 && (s - last_start - FRAME) > TO_BITS * C)
      mpos = 0;
    last_start = s;
    if (bad_par) begin
      e.ep = 1; mpos = 0;
    end else if (!legal(mpos, ch)) begin
      e.ef = 1; mpos = 0;
    end else if (mpos == 3) begin
      e.rec = 1; e.resp = {mslot[0], mslot[1], mslot[2], ch}; mpos = 0;
    end else begin
      mslot[mpos] = ch; mpos++;
    end
    evq.push_back(e);
  endtask

  task automatic model_reset();
    evq.delete();
    mpos = 0;
    last_start = -1;
    exp_resp = '0;
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock) begin : cmp
    bit xr, xp, xf;
    xr = 0; xp = 0; xf = 0;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      xr = evq[0].rec; xp = evq[0].ep; xf = evq[0].ef;
      if (evq[0].rec) exp_resp = evq[0].resp;
      void'(evq.pop_front());
    end
    chk("recebido", 32'(recebido), 32'(xr));
    chk("erro_paridade", 32'(erro_paridade), 32'(xp));
    chk("erro_formato", 32'(erro_formato), 32'(xf));
    chk("resposta", 32'(resposta), 32'(exp_resp));
  end

  int n_rec = 0, n_ep = 0, n_ef = 0;
  always @(negedge clock) begin
    if (recebido) n_rec++;
    if (erro_paridade) n_ep++;
    if (erro_formato) n_ef++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    n_rec = 0; n_ep = 0; n_ef = 0;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send_char(input logic [6:0] ch, input bit bad_par);
    logic [8:0] bits;
    bits = {1'b1, (^ch) ^ bad_par, ch};
    model_frame(ch, bad_par, cyc);
    serial = 1'b0;
    for (int i = 0; i < 9; i++) begin
      idle(C);
      serial = bits[i];
    end
    idle(C);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    idle(3);
    chk("rst_resposta", 32'(resposta), 32'h0);
    chk("rst_db_estado", 32'(db_estado), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
    reset = 1'b1;
    idle(5);

    // 1: single message
    clear_counts();
    send_str("A$2#");
    idle(10);
    chk("t1_resposta", 32'(resposta), 32'h8291923);
    chk("t1_n_rec", 32'(n_rec), 32'd1);
    chk("t1_n_err", 32'(n_ep + n_ef), 32'd0);
    chk("t1_ocupado", 32'(ocupado), 32'h0);

    // 2: two messages back to back
    clear_counts();
    send_str("J$0#");
    send_str("D$3#");
    idle(10);
    chk("t2_resposta", 32'(resposta), 32'h88919A3);
    chk("t2_n_rec", 32'(n_rec), 32'd2);

    // 3: parity error on '$', then a good message
    clear_counts();
    send_char(7'h42, 1'b0);
    send_char(7'h24, 1'b1);
    send_char(7'h31, 1'b0);
    send_char(7'h23, 1'b0);
    send_str("C$1#");
    idle(10);
    chk("t3_n_ep", 32'(n_ep), 32'd1);
    chk("t3_n_ef", 32'(n_ef), 32'd2);
    chk("t3_n_rec", 32'(n_rec), 32'd1);
    chk("t3_resposta", 32'(resposta), 32'h86918A3);

    // 4: illegal position char, stray '#', then good message
    clear_counts();
    send_str("A$7#");
    send_str("Z$0#");
    idle(10);
    chk("t4_n_ef", 32'(n_ef), 32'd2);
    chk("t4_n_ep", 32'(n_ep), 32'd0);
    chk("t4_n_rec", 32'(n_rec), 32'd1);
    chk("t4_resposta", 32'(resposta), 32'hB491823);

    // 5: inter-character timeout
    clear_counts();
    send_str("A$");
    idle(20 * C);
    chk("t5_ocupado_wait", 32'(ocupado), 32'h1);
    idle(21 * C);
    chk("t5_ocupado_dropped", 32'(ocupado), 32'h0);
    send_str("2#");
    idle(10);
    chk("t5_n_ef", 32'(n_ef), 32'd2);
    chk("t5_n_rec", 32'(n_rec), 32'd0);
    chk("t5_resposta", 32'(resposta), 32'hB491823);

    // zera between characters: partial message dropped, resposta kept
    clear_counts();
    send_str("A$");
    idle(2);
    zera = 1'b1;
    idle(1);
    zera = 1'b0;
    mpos = 0;
    chk("zera_ocupado", 32'(ocupado), 32'h0);
    send_str("2#");
    idle(10);
    chk("zera_n_ef", 32'(n_ef), 32'd2);
    chk("zera_n_rec", 32'(n_rec), 32'd0);
    chk("zera_resposta", 32'(resposta), 32'hB491823);

    // 6a: one-tick glitch
    clear_counts();
    g = cyc;
    serial = 1'b0;
    idle(1);
    serial = 1'b1;
    idle(3);
    chk("glitch_cycle", 32'(cyc - g), 32'd4);
    chk("glitch_start", 32'(db_estado), 32'd1);
    idle(4);
    chk("glitch_idle", 32'(db_estado), 32'd0);
    idle(10);
    chk("glitch_pulses", 32'(n_rec + n_ep + n_ef), 32'd0);
    chk("glitch_ocupado", 32'(ocupado), 32'h0);

    // 6b: reset in the middle of DATA
    serial = 1'b0;
    idle(C / 2 + 2 * C + 3);
    chk("mid_db_data", 32'(db_estado), 32'd2);
    chk("mid_ocupado", 32'(ocupado), 32'h1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_resposta", 32'(resposta), 32'h0);
    chk("async_db", 32'(db_estado), 32'h0);
    chk("async_ocupado", 32'(ocupado), 32'h0);
    chk("async_pulses", 32'({recebido, erro_paridade, erro_formato}), 32'h0);
    idle(3);
    reset = 1'b1;
    idle(20);
    chk("post_rst_low_line_db", 32'(db_estado), 32'd0);
    chk("post_rst_low_line_ocupado", 32'(ocupado), 32'h0);
    serial = 1'b1;
    idle(2 * C);
    clear_counts();
    send_str("A$2#");
    idle(10);
    chk("t6_n_rec", 32'(n_rec), 32'd1);
    chk("t6_n_err", 32'(n_ep + n_ef), 32'd0);
    chk("t6_resposta", 32'(resposta), 32'h8291923);
    chk("model_drained", 32'(evq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
